mlp_frame_sequencer: RTL and testbench
======================================

Name: mlp_frame_sequencer

Overview:
- Sequences the free-running, unhandshaked two-layer MLP datapath.
- Collects a streamed sample window of N_IN (mag, pol) pairs, presents one complete frame to the datapath for one cycle, and tracks the frame through the fixed pipeline latency with a valid shift register.
- Captures each result into an output FIFO with valid/ready handshake.
- Credit counting guarantees no result is ever dropped under backpressure.

Parameters:
- N_IN, 49, samples per frame (datapath input width N1/2).
- W_X, 4, sample magnitude width.
- W_Y, 21, datapath result width.
- LATENCY, 13, cycles from issue cycle to datapath result valid; must be >=1.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >=2.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  sequencer can accept a sample.
- s_mag  in  W_X  sample magnitude.
- s_pol  in  1  sample polarity.
- s_last  in  1  marks last sample of an image; forces frame end (zero pad).
- flush  in  1  synchronous discard of the partial frame.
- mlp_mag  out  N_IN*W_X  frame magnitudes to datapath; element 0 = first sample.
- mlp_pol  out  N_IN  frame polarities to datapath.
- mlp_issue  out  1  frame on mlp_* is valid this cycle.
- mlp_out  in  W_Y  datapath result.
- m_valid  out  1  result available.
- m_ready  in  1  downstream accepts result.
- m_data  out  W_Y  result, issue order.
- m_last  out  1  result belongs to the frame closed by s_last.
- busy  out  1  any frame partial, in flight, or in the FIFO.

Behaviour:
- Reset: all outputs 0; fill count 0; credits = FIFO_DEPTH; valid pipe clear; FIFO empty; buffers 0.
- States:
  - FILL: s_ready=1. Each s_valid&s_ready writes the sample to slot cnt; cnt++.
  - Go to FULL when cnt reaches N_IN-1 with a write, or on any write with s_last=1. Slots above the last written slot read as mag=0, pol=0.
- FULL: s_ready=0.
  - If credits>0: mlp_issue=1 for exactly one cycle, with mlp_mag/mlp_pol stable from registers. Credits decrement, cnt clears, and the state returns to FILL next cycle.
  - If credits==0: hold FULL with mlp_* stable and mlp_issue=0.
  - Minimum frame period is N_IN+1 cycles.
- mlp_* outputs hold their last values outside issue; the datapath samples only the issue cycle.
- Valid pipe:
  - LATENCY-bit shift register carries (issue, last) tags.
  - On tag exit, mlp_out is written into the FIFO on that same cycle, with the last tag.
- FIFO: m_valid = !empty. A pop on m_valid&m_ready returns one credit.
- Credits: an issue and a pop in the same cycle leave credits unchanged. Credits never exceed FIFO_DEPTH, so a FIFO write never finds the FIFO full (assertion).
- flush: in FILL or FULL, clears cnt and zeroes the slots; return to FILL next cycle.
  - flush has priority over a same-cycle sample write.
  - A same-cycle issue still completes; flush acts on the next frame.
  - In-flight and FIFO results are unaffected.
- busy = cnt!=0 | state==FULL | any pipe tag | !empty.
- Reset asserted mid-operation discards everything: partial frame, in-flight tags, FIFO contents. Results emerging from the datapath afterwards are ignored because the tags are cleared.
- Arithmetic: cnt width $clog2(N_IN+1); credit width $clog2(FIFO_DEPTH+1). FIFO pointers have one extra wrap bit; full/empty come from pointer comparison.

Decomposition:
- Package mlp_pkg:
  - N_IN, W_X, W_Y, LATENCY defaults.
  - typedef sample_t {mag, pol}.
  - typedef result_t {data, last}.
- One sub-module: mlp_result_fifo (synchronous FIFO, parameters DEPTH and width; ports push/pop/full/empty).
- Sequencer FSM, fill buffer, valid pipe and credits live in mlp_frame_sequencer.

Test Plan:
- Single frame: 49 samples mag=1..49 mod 16, pol alternating, m_ready=1.
  - mlp_issue pulses once, exactly 1 cycle after the 49th accept, with slot order correct.
  - A stub result 0x1234 fed LATENCY cycles later appears as m_data=0x1234 the next cycle.
- Short frame: 10 samples with s_last on the 10th.
  - Slots 10..48 are zero.
  - Issue occurs, and m_last=1 on that frame's result.
- Backpressure: m_ready=0, stream 6 full frames.
  - Exactly 4 issues occur; the 5th frame holds FULL with s_ready=0 and no FIFO overflow.
  - Raising m_ready releases results in order and the remaining 2 frames issue.
- Flush: flush after 20 samples, with a sample presented the same cycle.
  - cnt returns to 0 and the sample is discarded.
  - The next 49 samples form one clean frame.
- Reset mid-flight: rstn low 2 cycles, 5 cycles after an issue.
  - All outputs 0, m_valid never asserts for that frame, credits=4 after release.
- Back-to-back frames with m_ready=1: issue period is exactly 50 cycles and busy stays high throughout.

Source files
------------

// File: rtl/mlp_pkg.sv
// +----------------------------------------------------------------+
// | mlp_pkg: shared sizes and types for the MLP frame sequencer    |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

package mlp_pkg;

  localparam int N_IN       = 49;
  localparam int W_X        = 4;
  localparam int W_Y        = 21;
  localparam int LATENCY    = 13;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [W_X-1:0] mag;
    logic           pol;
  } sample_t;

  typedef struct packed {
    logic [W_Y-1:0] data;
    logic           last;
  } result_t;

endpackage

`default_nettype wire

// File: rtl/mlp_result_fifo.sv
// +----------------------------------------------------------------+
// | mlp_result_fifo: synchronous FIFO with wrap-bit pointers        |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

module mlp_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Credit accounting upstream must make this impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(push && full));

endmodule

`default_nettype wire

// File: rtl/mlp_frame_sequencer.sv
// +----------------------------------------------------------------+
// | mlp_frame_sequencer: frames samples, tracks latency, buffers   |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

module mlp_frame_sequencer #(
  parameter int N_IN       = mlp_pkg::N_IN,
  parameter int W_X        = mlp_pkg::W_X,
  parameter int W_Y        = mlp_pkg::W_Y,
  parameter int LATENCY    = mlp_pkg::LATENCY,
  parameter int FIFO_DEPTH = mlp_pkg::FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [W_X-1:0]    s_mag,
  input  logic              s_pol,
  input  logic              s_last,
  input  logic              flush,
  output logic [N_IN*W_X-1:0] mlp_mag,
  output logic [N_IN-1:0]   mlp_pol,
  output logic              mlp_issue,
  input  logic [W_Y-1:0]    mlp_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [W_Y-1:0]    m_data,
  output logic              m_last,
  output logic              busy
);

  import mlp_pkg::*;

  localparam int CW = $clog2(N_IN + 1);
  localparam int KW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [0:0] {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [KW-1:0]        credits, credits_nxt;
  logic                 frame_last;
  logic [LATENCY-1:0]   pipe_v;
  logic [LATENCY-1:0]   pipe_l;
  sample_t              slot [N_IN];
  sample_t              s_in;
  logic                 accept, closing, pop;
  logic                 fifo_full, fifo_empty;
  result_t              wr_res, rd_res;

  assign s_in    = '{mag: s_mag, pol: s_pol};
  assign accept  = s_valid & s_ready;
  assign closing = accept & (s_last | (cnt == CW'(N_IN - 1)));
  assign pop     = m_valid & m_ready;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    credits_nxt = credits;
    if (mlp_issue) credits_nxt = credits_nxt - KW'(1);
    if (pop)       credits_nxt = credits_nxt + KW'(1);
    // An issue already on the wires completes even when flush lands with it.
    if (flush) begin
      state_nxt = FILL;
      cnt_nxt   = '0;
    end else if (state == FILL) begin
      if (accept)  cnt_nxt   = cnt + 1'b1;
      if (closing) state_nxt = FULL;
    end else if (mlp_issue) begin
      state_nxt = FILL;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= FILL;
      cnt        <= '0;
      credits    <= KW'(FIFO_DEPTH);
      s_ready    <= 1'b0;
      mlp_issue  <= 1'b0;
      frame_last <= 1'b0;
      pipe_v     <= '0;
      pipe_l     <= '0;
      for (int i = 0; i < N_IN; i++) slot[i] <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      credits   <= credits_nxt;
      s_ready   <= (state_nxt == FILL);
      mlp_issue <= (state_nxt == FULL) && (credits_nxt != '0);
      pipe_v[0] <= mlp_issue;
      pipe_l[0] <= mlp_issue & frame_last;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_l[i] <= pipe_l[i-1];
      end
      if (flush)        frame_last <= 1'b0;
      else if (closing) frame_last <= s_last;
      // A short frame zero-pads every slot above its final sample.
      for (int i = 0; i < N_IN; i++) begin
        if (flush)                                 slot[i] <= '0;
        else if (accept && (CW'(i) == cnt))        slot[i] <= s_in;
        else if (accept && s_last && (CW'(i) > cnt)) slot[i] <= '0;
      end
    end
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_frame_out
    assign mlp_mag[g*W_X +: W_X] = slot[g].mag;
    assign mlp_pol[g]            = slot[g].pol;
  end

  assign wr_res = '{data: mlp_out, last: pipe_l[LATENCY-1]};

  mlp_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(result_t))
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (pipe_v[LATENCY-1]),
    .wdata (wr_res),
    .pop   (pop),
    .rdata (rd_res),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_valid = ~fifo_empty;
  assign m_data  = rd_res.data;
  assign m_last  = rd_res.last;
  assign busy    = (cnt != '0) | (state == FULL) | (|pipe_v) | ~fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_mlp_frame_sequencer.sv
// +----------------------------------------------------------------+
// | tb_mlp_frame_sequencer: directed bench with datapath stub      |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

module tb_mlp_frame_sequencer;
  import mlp_pkg::*;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                s_valid = 1'b0, s_pol = 1'b0, s_last = 1'b0, flush = 1'b0, m_ready = 1'b0;
  logic [W_X-1:0]      s_mag = '0;
  logic [W_Y-1:0]      mlp_out = '0;
  logic                s_ready, mlp_issue, m_valid, m_last, busy;
  logic [N_IN*W_X-1:0] mlp_mag;
  logic [N_IN-1:0]     mlp_pol;
  logic [W_Y-1:0]      m_data;

  mlp_frame_sequencer dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_mag(s_mag),
    .s_pol(s_pol), .s_last(s_last), .flush(flush), .mlp_mag(mlp_mag), .mlp_pol(mlp_pol),
    .mlp_issue(mlp_issue), .mlp_out(mlp_out), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [W_Y-1:0] val; } stub_t;

  int n_cmp = 0, n_err = 0, cyc = 0;
  int issue_cnt = 0, pop_cnt = 0, mvalid_cnt = 0, busy_low = 0, last_acc_cyc = 0;
  bit mon_busy = 1'b0;
  logic [N_IN*W_X-1:0] snap_mag, fr_mag;
  logic [N_IN-1:0]     snap_pol, fr_pol;
  stub_t   stub_q[$];
  result_t exp_q[$];
  bit      flast_q[$];
  int      issue_cyc_q[$];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: record this cycle's activity, advance, then drive the datapath stub.
  task automatic tick();
    logic [W_Y-1:0] v;
    bit fl;
    if (mlp_issue) begin
      v  = W_Y'(32'h1234 + issue_cnt * 32'h111);
      fl = (flast_q.size() != 0) ? flast_q.pop_front() : 1'b0;
      snap_mag = mlp_mag;
      snap_pol = mlp_pol;
      issue_cyc_q.push_back(cyc);
      stub_q.push_back('{cyc: cyc, val: v});
      exp_q.push_back('{data: v, last: fl});
      issue_cnt++;
    end
    if (m_valid) mvalid_cnt++;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("pop_spurious", 1'b1, 1'b0);
      end else begin
        check_eq("pop_data", m_data, exp_q[0].data);
        check_eq("pop_last", m_last, exp_q[0].last);
        void'(exp_q.pop_front());
      end
      pop_cnt++;
    end
    if (mon_busy && !busy) busy_low++;
    @(posedge clk);
    #1;
    cyc++;
    if (stub_q.size() != 0 && stub_q[0].cyc + LATENCY == cyc) begin
      mlp_out = stub_q[0].val;
      void'(stub_q.pop_front());
    end else begin
      mlp_out = W_Y'(32'h1F0F0);
    end
  endtask

  task automatic send(input logic [W_X-1:0] mag, input logic pol, input logic last);
    int g = 0;
    s_valid = 1'b1; s_mag = mag; s_pol = pol; s_last = last;
    while (!s_ready && g < 3000) begin tick(); g++; end
    if (!s_ready) check_eq("s_ready_timeout", 1'b0, 1'b1);
    last_acc_cyc = cyc;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Streams n samples (mag = seed+i mod 16, pol = bit 0 of that) and builds the expected frame.
  task automatic send_samples(input int n, input int seed, input bit last);
    fr_mag = '0;
    fr_pol = '0;
    for (int i = 0; i < n; i++) begin
      fr_mag[i*W_X +: W_X] = W_X'(seed + i);
      fr_pol[i]            = 1'((seed + i) & 1);
      send(W_X'(seed + i), 1'((seed + i) & 1), last && (i == n - 1));
    end
  endtask

  task automatic send_frame(input int n, input int seed, input bit last);
    send_samples(n, seed, last);
    flast_q.push_back(last);
  endtask

  task automatic wait_issue(input int bound);
    int start = issue_cnt;
    int g = 0;
    while (issue_cnt == start && g < bound) begin tick(); g++; end
    check_eq("issue_seen", issue_cnt != start, 1'b1);
  endtask

  task automatic wait_mvalid(input int bound);
    int g = 0;
    while (!m_valid && g < bound) begin tick(); g++; end
    check_eq("m_valid_seen", m_valid, 1'b1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_s_ready"}, s_ready, 1'b0);
    check_eq({tag, "_issue"},   mlp_issue, 1'b0);
    check_eq({tag, "_m_valid"}, m_valid, 1'b0);
    check_eq({tag, "_busy"},    busy, 1'b0);
    check_eq({tag, "_m_data"},  m_data, '0);
    check_eq({tag, "_mag"},     mlp_mag, '0);
  endtask

  initial begin
    int base, pbase, mv, n;

    // Reset state
    tick(); tick();
    check_outputs_zero("rst");
    check_eq("rst_credits", dut.credits, 4);
    rstn = 1'b1;
    tick(); tick();
    check_eq("s_ready_after_rst", s_ready, 1'b1);

    // Single full frame
    m_ready = 1'b1;
    send_frame(N_IN, 1, 1'b0);
    wait_issue(20);
    check_eq("issue_latency", issue_cyc_q[$], last_acc_cyc + 1);
    check_eq("frame1_mag", snap_mag, fr_mag);
    check_eq("frame1_pol", snap_pol, fr_pol);
    wait_mvalid(40);
    check_eq("result_cycle", cyc, issue_cyc_q[$] + LATENCY + 1);
    check_eq("result_data", m_data, 21'h1234);
    check_eq("result_last", m_last, 1'b0);
    repeat (5) tick();
    check_eq("issue_once", issue_cnt, 1);

    // Short frame closed by s_last
    send_frame(10, 7, 1'b1);
    wait_issue(20);
    check_eq("short_mag", snap_mag, fr_mag);
    check_eq("short_pol", snap_pol, fr_pol);
    wait_mvalid(40);
    check_eq("short_data", m_data, 21'h1345);
    check_eq("short_last", m_last, 1'b1);
    repeat (5) tick();

    // Backpressure: six frames, only four credits
    m_ready = 1'b0;
    base  = issue_cnt;
    pbase = pop_cnt;
    for (int f = 0; f < 5; f++) send_frame(N_IN, 3 + f, 1'b0);
    repeat (60) tick();
    check_eq("bp_issues", issue_cnt - base, 4);
    check_eq("bp_s_ready", s_ready, 1'b0);
    check_eq("bp_issue_low", mlp_issue, 1'b0);
    check_eq("bp_m_valid", m_valid, 1'b1);
    check_eq("bp_busy", busy, 1'b1);
    m_ready = 1'b1;
    send_frame(N_IN, 8, 1'b0);
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 400) begin tick(); n++; end
    check_eq("bp_all_issued", issue_cnt - base, 6);
    check_eq("bp_all_popped", pop_cnt - pbase, 6);

    // Flush with a same-cycle sample
    send_samples(20, 2, 1'b0);
    s_valid = 1'b1; s_mag = 4'h5; s_pol = 1'b1; flush = 1'b1;
    tick();
    s_valid = 1'b0; flush = 1'b0;
    check_eq("flush_cnt", dut.cnt, 0);
    check_eq("flush_busy", busy, 1'b0);
    check_eq("flush_slots", mlp_mag, '0);
    send_frame(N_IN, 9, 1'b0);
    wait_issue(20);
    check_eq("post_flush_mag", snap_mag, fr_mag);
    check_eq("post_flush_pol", snap_pol, fr_pol);
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 100) begin tick(); n++; end

    // Reset while a frame is in flight
    send_frame(N_IN, 4, 1'b0);
    wait_issue(20);
    repeat (4) tick();
    rstn = 1'b0;
    #2;
    check_outputs_zero("midrst");
    exp_q.delete();
    flast_q.delete();
    tick(); tick();
    rstn = 1'b1;
    mv = mvalid_cnt;
    repeat (LATENCY + 10) tick();
    check_eq("midrst_no_result", mvalid_cnt - mv, 0);
    check_eq("midrst_credits", dut.credits, 4);

    // Back-to-back frames
    base = issue_cyc_q.size();
    send_frame(N_IN, 5, 1'b0);
    mon_busy = 1'b1;
    send_frame(N_IN, 6, 1'b0);
    send_frame(N_IN, 11, 1'b0);
    wait_issue(20);
    mon_busy = 1'b0;
    check_eq("b2b_issues", issue_cyc_q.size() - base, 3);
    if (issue_cyc_q.size() - base == 3) begin
      check_eq("b2b_period1", issue_cyc_q[base+1] - issue_cyc_q[base], N_IN + 1);
      check_eq("b2b_period2", issue_cyc_q[base+2] - issue_cyc_q[base+1], N_IN + 1);
    end
    check_eq("b2b_busy", busy_low, 0);
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 100) begin tick(); n++; end
    check_eq("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
